// File: rtl/rv_pkg.sv
// Shared integer-pipeline definitions.
// Load funct3 encodings and the writeback FSM state type.
package rv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        COMMIT    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_commit_unit_load_extract.sv
// Sub-word load extraction.
// Selects a byte/half from the aligned word and extends it.
module load_extract
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    // misaligned halves use addr_lo[1] only
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // extend the selected lane; LW and unknown codes pass the word
    always_comb begin
        o_result = i_rdata;
        case (i_funct3)
            F3_LB:   o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_result = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  o_result = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_result = {{(XLEN-16){1'b0}}, w_half};
            F3_LW:   o_result = i_rdata;
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: one registered register-file write
// per instruction, frozen while the memory system stalls.
module wb_commit_unit
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wait_mem,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [CNT_W-1:0] instret
);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;
    logic              r_we;
    logic [4:0]        r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [CNT_W-1:0]  r_instret;
    logic [4:0]        r_rd;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;

    logic              w_acc;
    logic              w_writes;
    logic              w_load;
    logic              w_pend;
    logic [2:0]        w_f3_sel;
    logic [1:0]        w_al_sel;
    logic [XLEN-1:0]   w_ext;
    logic              w_we_nxt;
    logic [4:0]        w_waddr_nxt;
    logic [XLEN-1:0]   w_wdata_nxt;
    logic [1:0]        w_inc;
    logic              w_latch;

    assign in_ready = (r_state == IDLE)
                    | ((r_state == COMMIT) & ~wait_mem);
    assign w_acc    = in_valid & in_ready & ~wait_mem;
    assign w_writes = in_reg_write & (in_rd != 5'd0);
    assign w_load   = w_writes & in_mem_to_reg;
    assign w_pend   = r_state == LOAD_WAIT;

    // pending load uses its latched context, else the live one
    assign w_f3_sel = w_pend ? r_funct3  : in_funct3;
    assign w_al_sel = w_pend ? r_addr_lo : in_addr_lo;

    load_extract #(.XLEN(XLEN)) u_ext (
        .i_funct3  (w_f3_sel),
        .i_addr_lo (w_al_sel),
        .i_rdata   (dmem_rdata),
        .o_result  (w_ext)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state logic; a stall freezes everything
    always_comb begin
        w_state_nxt = r_state;
        if (!wait_mem) begin
            case (r_state)
                IDLE, COMMIT: begin
                    if (!w_acc)          w_state_nxt = IDLE;
                    else if (!w_writes)  w_state_nxt = IDLE;
                    else if (!w_load)    w_state_nxt = COMMIT;
                    else if (dmem_rvalid) w_state_nxt = COMMIT;
                    else                 w_state_nxt = LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (dmem_rvalid) w_state_nxt = COMMIT;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // write-port contents, retire increment and context capture
    always_comb begin
        w_we_nxt    = w_state_nxt == COMMIT;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_latch     = 1'b0;
        w_inc       = 2'd0;
        if (!wait_mem) begin
            if (r_state == COMMIT)
                w_inc = w_inc + 2'd1;
            if (w_acc & ~w_writes)
                w_inc = w_inc + 2'd1;
            if (w_pend & dmem_rvalid) begin
                w_waddr_nxt = r_rd;
                w_wdata_nxt = w_ext;
            end else if (w_acc & w_writes & ~w_load) begin
                w_waddr_nxt = in_rd;
                w_wdata_nxt = in_alu_result;
            end else if (w_acc & w_load & dmem_rvalid) begin
                w_waddr_nxt = in_rd;
                w_wdata_nxt = w_ext;
            end else if (w_acc & w_load) begin
                w_latch = 1'b1;
            end
        end
    end

    // registered write port and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_waddr   <= 5'd0;
            r_wdata   <= '0;
            r_instret <= '0;
        end else begin
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_instret <= r_instret + CNT_W'(w_inc);
        end
    end

    // load context held across LOAD_WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd      <= 5'd0;
            r_funct3  <= 3'd0;
            r_addr_lo <= 2'd0;
        end else if (w_latch) begin
            r_rd      <= in_rd;
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr_lo;
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign instret  = r_instret;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: transaction-level model checked
// every cycle, plus literal expectations on directed vectors.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wait_mem = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic        in_mem_to_reg = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic [31:0] in_alu_result = 32'd0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] instret;

    int n_chk = 0;
    int n_fail = 0;

    wb_commit_unit dut (
        .clk           (clk),
        .rst           (rst),
        .wait_mem      (wait_mem),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_rd         (in_rd),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_we;
    bit [4:0]    m_waddr;
    bit [31:0]   m_wdata;
    bit [31:0]   m_instret;
    bit          m_pend;
    bit [4:0]    m_prd;
    bit [2:0]    m_pf3;
    bit [1:0]    m_pal;

    function automatic bit [31:0] m_ext(bit [2:0] f3, bit [1:0] al,
                                        bit [31:0] d);
        bit [31:0] b, h;
        b = (d >> (al * 8)) & 32'hFF;
        h = (d >> ((al / 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic bit m_ready();
        return !m_pend && (!m_we || !wait_mem);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_we = 0; m_waddr = 0; m_wdata = 0;
            m_instret = 0; m_pend = 0;
        end else if (!wait_mem) begin
            bit rdy, nwe;
            int inc;
            rdy = m_ready();
            inc = m_we ? 1 : 0;
            nwe = 0;
            if (m_pend) begin
                if (dmem_rvalid) begin
                    nwe = 1; m_pend = 0; m_waddr = m_prd;
                    m_wdata = m_ext(m_pf3, m_pal, dmem_rdata);
                end
            end else if (in_valid && rdy) begin
                if (!in_reg_write || in_rd == 0) inc++;
                else if (!in_mem_to_reg) begin
                    nwe = 1; m_waddr = in_rd; m_wdata = in_alu_result;
                end else if (dmem_rvalid) begin
                    nwe = 1; m_waddr = in_rd;
                    m_wdata = m_ext(in_funct3, in_addr_lo, dmem_rdata);
                end else begin
                    m_pend = 1; m_prd = in_rd;
                    m_pf3 = in_funct3; m_pal = in_addr_lo;
                end
            end
            m_we = nwe;
            m_instret = m_instret + inc;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("m_we", {31'd0, rf_we}, {31'd0, m_we});
            check("m_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
            check("m_wdata", rf_wdata, m_wdata);
            check("m_instret", instret, m_instret);
            check("m_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
        in_rd = 0; in_funct3 = 0; in_addr_lo = 0;
        in_alu_result = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic offer(input bit rw, input bit mtr, input bit [4:0] rd,
                         input bit [2:0] f3, input bit [1:0] al,
                         input bit [31:0] alu);
        in_valid = 1; in_reg_write = rw; in_mem_to_reg = mtr;
        in_rd = rd; in_funct3 = f3; in_addr_lo = al;
        in_alu_result = alu;
    endtask

    initial begin
        #12;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_instret", instret, 32'd0);
        rst = 0;
        step();

        // ALU write rd=5
        offer(1, 0, 5'd5, 3'd0, 2'd0, 32'h1234_5678);
        step(); clr();
        @(negedge clk);
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234_5678);
        step();
        @(negedge clk);
        check("alu_instret", instret, 32'd1);

        // LB rd=7 addr_lo=3, data three edges later
        offer(1, 1, 5'd7, 3'b000, 2'd3, 32'h0);
        step(); clr();
        @(negedge clk);
        check("lb_ready", {31'd0, in_ready}, 32'd0);
        step(); step();
        dmem_rvalid = 1; dmem_rdata = 32'h80FF_0011;
        step(); clr();
        @(negedge clk);
        check("lb_waddr", {27'd0, rf_waddr}, 32'd7);
        check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        step();

        // LHU addr_lo=2 with data in the accept cycle
        offer(1, 1, 5'd9, 3'b101, 2'd2, 32'h0);
        dmem_rvalid = 1; dmem_rdata = 32'h8001_0000;
        step(); clr();
        @(negedge clk);
        check("lhu_we", {31'd0, rf_we}, 32'd1);
        check("lhu_wdata", rf_wdata, 32'h0000_8001);
        step();

        // misaligned LH uses addr_lo[1] only
        offer(1, 1, 5'd11, 3'b001, 2'd1, 32'h0);
        dmem_rvalid = 1; dmem_rdata = 32'h1234_8000;
        step(); clr();
        @(negedge clk);
        check("lh_mis_wdata", rf_wdata, 32'hFFFF_8000);
        // back-to-back LBU accepted during that COMMIT
        offer(1, 1, 5'd12, 3'b100, 2'd1, 32'h0);
        dmem_rvalid = 1; dmem_rdata = 32'h0000_9A00;
        step(); clr();
        @(negedge clk);
        check("lbu_wdata", rf_wdata, 32'h0000_009A);
        step();
        @(negedge clk);
        check("pre_stall_instret", instret, 32'd5);

        // COMMIT rd=3 stalled four cycles, rd=4 waiting behind it
        offer(1, 0, 5'd3, 3'd0, 2'd0, 32'h0000_CAFE);
        step();
        offer(1, 0, 5'd4, 3'd0, 2'd0, 32'h0000_BEEF);
        wait_mem = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("stall_waddr", {27'd0, rf_waddr}, 32'd3);
            check("stall_wdata", rf_wdata, 32'h0000_CAFE);
            check("stall_instret", instret, 32'd5);
        end
        #2;
        wait_mem = 0;
        step(); clr();
        @(negedge clk);
        check("post_stall_instret", instret, 32'd6);
        check("post_stall_waddr", {27'd0, rf_waddr}, 32'd4);
        step();

        // rd=0 during COMMIT, then a store
        offer(1, 0, 5'd6, 3'd0, 2'd0, 32'h0000_0066);
        step();
        offer(1, 0, 5'd0, 3'd0, 2'd0, 32'h0000_0077);
        step();
        offer(0, 0, 5'd8, 3'd0, 2'd0, 32'h0000_0088);
        @(negedge clk);
        check("x0_instret", instret, 32'd9);
        check("x0_we", {31'd0, rf_we}, 32'd0);
        step(); clr();
        @(negedge clk);
        check("store_instret", instret, 32'd10);
        check("store_waddr", {27'd0, rf_waddr}, 32'd6);

        // reset while a load is pending, then a stray rvalid
        offer(1, 1, 5'd10, 3'b010, 2'd0, 32'h0);
        step(); clr();
        rst = 1; #2; rst = 0;
        @(negedge clk);
        check("rstl_instret", instret, 32'd0);
        check("rstl_we", {31'd0, rf_we}, 32'd0);
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        step(); clr();
        @(negedge clk);
        check("stray_we", {31'd0, rf_we}, 32'd0);
        check("stray_waddr", {27'd0, rf_waddr}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
